// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: owner and state encodings,
// the request bundle, and a helper for the round-robin pick.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      DMA  = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   localparam int REQ_AW = 32;
   localparam int REQ_DW = 32;

   // Request bundle at the default 32-bit address/data widths.
   typedef struct packed {
      logic                  we;
      logic [REQ_DW/8-1:0]   be;
      logic [REQ_AW-1:0]     addr;
      logic [REQ_DW-1:0]     wdata;
   } req_t;

   function automatic owner_t other_owner(input owner_t o);
      return (o == CPU) ? DMA : CPU;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick with a burst cap: the last owner keeps the memory
// under contention until it has taken MAX_BURST consecutive grants.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int CW        = 3,
   parameter int MAX_BURST = 4
) (
   input  logic          cpu_req,
   input  logic          dma_req,
   input  owner_t        last_owner,
   input  logic [CW-1:0] burst_cnt,
   output owner_t        winner
);

   always_comb begin
      winner = NONE;
      if (cpu_req && dma_req) begin
         winner = (burst_cnt < CW'(MAX_BURST)) ? last_owner : other_owner(last_owner);
      end else if (cpu_req) begin
         winner = CPU;
      end else if (dma_req) begin
         winner = DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory between the CPU and the DMA/loader
// port: one registered access per grant, registered read data, ready pulse.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [DW/8-1:0] cpu_be,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [DW-1:0]   cpu_wdata,
   output logic [DW-1:0]   cpu_rdata,
   output logic            cpu_ready,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [DW/8-1:0] dma_be,
   input  logic [AW-1:0]   dma_addr,
   input  logic [DW-1:0]   dma_wdata,
   output logic [DW-1:0]   dma_rdata,
   output logic            dma_ready,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   output owner_t          owner,
   output arb_state_t      state_dbg
);

   localparam int BW = DW/8;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   // Handshake: a master raises req with stable fields and holds them until
   // its one-cycle ready pulse; it may drop req or present the next request
   // at the edge ending ready. Fields are latched at grant.
   arb_state_t      state_q, state_d;
   owner_t          owner_q, owner_d;
   owner_t          last_q, last_d;
   logic [CW-1:0]   burst_q, burst_d;
   logic            we_q, we_d;
   logic [BW-1:0]   be_q, be_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   owner_t          winner;

   rr_pick #(
      .CW        (CW),
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .last_owner (last_q),
      .burst_cnt  (burst_q),
      .winner     (winner)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (winner != NONE) begin
               state_d = ACCESS;
               owner_d = winner;
               if (winner == CPU) begin
                  we_d    = cpu_we;
                  be_d    = cpu_be;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end else begin
                  we_d    = dma_we;
                  be_d    = dma_be;
                  addr_d  = dma_addr;
                  wdata_d = dma_wdata;
               end
               if (winner == last_q) begin
                  burst_d = (burst_q < BURST_MAX) ? burst_q + CW'(1) : BURST_MAX;
               end else begin
                  burst_d = CW'(1);
                  last_d  = winner;
               end
            end
         end
         ACCESS: begin
            rdata_d = mem_rdata;
            state_d = ACK;
         end
         ACK: begin
            state_d = IDLE;
            owner_d = NONE;
         end
         default: begin
            state_d = IDLE;
            owner_d = NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= NONE;
         last_q  <= CPU;
         burst_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Gating by state lets the write strobe drop the moment reset clears state.
   assign mem_we    = (state_q == ACCESS) && we_q && (be_q != '0);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign cpu_ready = (state_q == ACK) && (owner_q == CPU);
   assign dma_ready = (state_q == ACK) && (owner_q == DMA);
   assign cpu_rdata = rdata_q;
   assign dma_rdata = rdata_q;
   assign owner     = owner_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-master
// traffic checked against an arbitration/memory reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int MAXB = 4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic            cpu_req, cpu_we, cpu_ready;
   logic [BW-1:0]   cpu_be;
   logic [AW-1:0]   cpu_addr;
   logic [DW-1:0]   cpu_wdata, cpu_rdata;
   logic            dma_req, dma_we, dma_ready;
   logic [BW-1:0]   dma_be;
   logic [AW-1:0]   dma_addr;
   logic [DW-1:0]   dma_wdata, dma_rdata;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;
   logic            mem_we;
   logic [BW-1:0]   mem_be;
   owner_t          owner;
   arb_state_t      state_dbg;

   logic [31:0] mem     [0:63];
   logic [31:0] exp_mem [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   int n_total = 0;
   int n_pass  = 0;
   logic [DW-1:0] exp_q[$];

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_be    (cpu_be),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_be    (dma_be),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ready (dma_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .state_dbg (state_dbg)
   );

   // behavioural memory: combinational read, byte-enabled write on the edge
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (mem_we) begin
         for (int b = 0; b < BW; b++)
            if (mem_be[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_be = '0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = 6'(idx);
      pre_val = val;
      exp_mem[idx] = val;
      cyc();
      pre_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      cpu_req = 1; dma_req = 1; cpu_addr = 32'h40; dma_addr = 32'h44;
      reset = 1'b0;
      repeat (3) cyc();
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rst_cpu_ready: got %0b want 0", cpu_ready); else n_pass++;
      n_total++; if (dma_ready !== 1'b0) $display("FAIL rst_dma_ready: got %0b want 0", dma_ready); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %0b want 0", mem_we); else n_pass++;
      n_total++; if (owner !== NONE) $display("FAIL rst_owner: got %0d want 0", owner); else n_pass++;
      n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else n_pass++;
      n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
      n_total++; if (state_dbg !== IDLE) $display("FAIL rst_state: got %0d want 0", state_dbg); else n_pass++;
      reset = 1'b1;
      cyc();
      n_total++; if (owner !== CPU) $display("FAIL rst_first_grant: got %0d want 1", owner); else n_pass++;
      cyc();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL rst_first_ready: got %0b want 1", cpu_ready); else n_pass++;
      cyc();
      idle_inputs();
      cyc();
   endtask

   task automatic test_cpu_read();
      do_reset();
      preload(16, 32'hDEADBEEF);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
      cyc();
      n_total++; if (owner !== CPU) $display("FAIL rd_owner: got %0d want 1", owner); else n_pass++;
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rd_early_ready: got %0b want 0", cpu_ready); else n_pass++;
      cyc();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL rd_ready: got %0b want 1", cpu_ready); else n_pass++;
      n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", cpu_rdata); else n_pass++;
      n_total++; if (dma_ready !== 1'b0) $display("FAIL rd_dma_ready: got %0b want 0", dma_ready); else n_pass++;
      cyc();
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rd_ready_one_cycle: got %0b want 0", cpu_ready); else n_pass++;
      n_total++; if (owner !== NONE) $display("FAIL rd_owner_release: got %0d want 0", owner); else n_pass++;
      idle_inputs();
      cyc();
   endtask

   task automatic test_dma_write();
      do_reset();
      preload(17, 32'hAABBCCDD);
      dma_req = 1; dma_we = 1; dma_be = 4'b0001; dma_addr = 32'h44; dma_wdata = 32'h11223344;
      cyc();
      n_total++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we: got %0b want 1", mem_we); else n_pass++;
      n_total++; if (mem_addr !== 32'h44) $display("FAIL wr_mem_addr: got %h want 44", mem_addr); else n_pass++;
      n_total++; if (mem_be !== 4'b0001) $display("FAIL wr_mem_be: got %b want 0001", mem_be); else n_pass++;
      n_total++; if (owner !== DMA) $display("FAIL wr_owner: got %0d want 2", owner); else n_pass++;
      cyc();
      n_total++; if (mem_we !== 1'b0) $display("FAIL wr_we_one_cycle: got %0b want 0", mem_we); else n_pass++;
      n_total++; if (dma_ready !== 1'b1) $display("FAIL wr_dma_ready: got %0b want 1", dma_ready); else n_pass++;
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL wr_cpu_ready: got %0b want 0", cpu_ready); else n_pass++;
      cyc();
      idle_inputs();
      exp_mem[17] = 32'hAABBCC44;
      n_total++; if (mem[17] !== 32'hAABBCC44) $display("FAIL wr_mem_word: got %h want aabbcc44", mem[17]); else n_pass++;
      cyc();
   endtask

   task automatic test_burst();
      owner_t run_owner;
      owner_t want;
      int     run_len;
      bit     got;
      do_reset();
      cpu_req = 1; cpu_addr = 32'h48;
      dma_req = 1; dma_addr = 32'h4C;
      run_owner = NONE;
      run_len   = 0;
      for (int k = 0; k < 24; k++) begin
         got = 0;
         for (int t = 0; t < 6 && !got; t++) begin
            cyc();
            if (owner != NONE) got = 1;
         end
         want = (((k / MAXB) % 2) == 0) ? CPU : DMA;
         n_total++; if (owner !== want) $display("FAIL burst_order[%0d]: got %0d want %0d", k, owner, want); else n_pass++;
         if (owner == run_owner) run_len++;
         else begin run_owner = owner; run_len = 1; end
         n_total++; if (run_len > MAXB) $display("FAIL burst_cap[%0d]: run %0d want <= %0d", k, run_len, MAXB); else n_pass++;
         cyc();
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_access();
      do_reset();
      preload(18, 32'h5555AAAA);
      cpu_req = 1; cpu_we = 1; cpu_be = 4'hF; cpu_addr = 32'h48; cpu_wdata = 32'h12345678;
      cyc();
      n_total++; if (mem_we !== 1'b1) $display("FAIL rsta_we_before: got %0b want 1", mem_we); else n_pass++;
      #1 reset = 1'b0;
      #1;
      n_total++; if (mem_we !== 1'b0) $display("FAIL rsta_we_async: got %0b want 0", mem_we); else n_pass++;
      cyc();
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rsta_no_ready: got %0b want 0", cpu_ready); else n_pass++;
      idle_inputs();
      cyc();
      reset = 1'b1;
      cyc();
      n_total++; if (mem[18] !== 32'h5555AAAA) $display("FAIL rsta_word: got %h want 5555aaaa", mem[18]); else n_pass++;
      n_total++; if (state_dbg !== IDLE) $display("FAIL rsta_state: got %0d want 0", state_dbg); else n_pass++;
      n_total++; if (cpu_ready !== 1'b0) $display("FAIL rsta_ready_after: got %0b want 0", cpu_ready); else n_pass++;
   endtask

   task automatic test_be_zero();
      do_reset();
      preload(16, 32'hCAFEF00D);
      cpu_req = 1; cpu_we = 1; cpu_be = 4'b0000; cpu_addr = 32'h40; cpu_wdata = 32'hFFFFFFFF;
      cyc();
      n_total++; if (mem_we !== 1'b0) $display("FAIL be0_mem_we: got %0b want 0", mem_we); else n_pass++;
      n_total++; if (owner !== CPU) $display("FAIL be0_owner: got %0d want 1", owner); else n_pass++;
      cyc();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL be0_ready: got %0b want 1", cpu_ready); else n_pass++;
      n_total++; if (cpu_rdata !== 32'hCAFEF00D) $display("FAIL be0_rdata: got %h want cafef00d", cpu_rdata); else n_pass++;
      cyc();
      idle_inputs();
      n_total++; if (mem[16] !== 32'hCAFEF00D) $display("FAIL be0_word: got %h want cafef00d", mem[16]); else n_pass++;
      cyc();
   endtask

   task automatic test_random();
      bit          pend [2];
      bit          retire [2];
      bit          prev_req [2];
      logic        r_we [2];
      logic [3:0]  r_be [2];
      logic [31:0] r_addr [2];
      logic [31:0] r_wd [2];
      owner_t      prev_owner;
      int          m_last, m_cnt, w, cur_w, idx;
      bit          ack_due;
      logic [31:0] exp_d;
      do_reset();
      for (int m = 0; m < 2; m++) begin pend[m] = 0; retire[m] = 0; prev_req[m] = 0; end
      prev_owner = NONE;
      m_last = 1; m_cnt = 0; cur_w = 0; ack_due = 0;
      for (int n = 0; n < 320; n++) begin
         cyc();
         for (int m = 0; m < 2; m++)
            if (retire[m]) begin pend[m] = 0; retire[m] = 0; end
         if (ack_due) begin
            ack_due = 0;
            n_total++; if (cpu_ready !== (cur_w == 1)) $display("FAIL rnd_cpu_ready@%0d: got %0b want %0b", n, cpu_ready, cur_w == 1); else n_pass++;
            n_total++; if (dma_ready !== (cur_w == 2)) $display("FAIL rnd_dma_ready@%0d: got %0b want %0b", n, dma_ready, cur_w == 2); else n_pass++;
            exp_d = exp_q.pop_front();
            n_total++; if (cpu_rdata !== exp_d) $display("FAIL rnd_rdata@%0d: got %h want %h", n, cpu_rdata, exp_d); else n_pass++;
            retire[cur_w-1] = 1;
         end else begin
            n_total++; if (cpu_ready !== 1'b0 || dma_ready !== 1'b0) $display("FAIL rnd_spurious_ready@%0d: got %0b%0b want 00", n, cpu_ready, dma_ready); else n_pass++;
         end
         if (prev_owner == NONE) begin
            if (prev_req[0] && prev_req[1]) w = (m_cnt < MAXB) ? m_last : 3 - m_last;
            else if (prev_req[0]) w = 1;
            else if (prev_req[1]) w = 2;
            else w = 0;
            n_total++; if (owner !== 2'(w)) $display("FAIL rnd_grant@%0d: got %0d want %0d", n, owner, w); else n_pass++;
            if (w != 0) begin
               if (w == m_last) m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
               else begin m_cnt = 1; m_last = w; end
               cur_w = w;
               ack_due = 1;
               idx = int'(r_addr[w-1][7:2]);
               exp_q.push_back(exp_mem[idx]);
               n_total++; if (mem_addr !== r_addr[w-1]) $display("FAIL rnd_addr@%0d: got %h want %h", n, mem_addr, r_addr[w-1]); else n_pass++;
               n_total++; if (mem_we !== (r_we[w-1] && r_be[w-1] != 0)) $display("FAIL rnd_we@%0d: got %0b want %0b", n, mem_we, r_we[w-1] && r_be[w-1] != 0); else n_pass++;
               if (r_we[w-1])
                  for (int b = 0; b < BW; b++)
                     if (r_be[w-1][b]) exp_mem[idx][b*8 +: 8] = r_wd[w-1][b*8 +: 8];
            end
         end
         prev_owner = owner;
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && n < 300 && $urandom_range(0, 2) != 0) begin
               pend[m]   = 1;
               r_we[m]   = 1'($urandom_range(0, 1));
               r_be[m]   = 4'($urandom_range(0, 15));
               r_addr[m] = 32'h40 + 32'($urandom_range(0, 15)) * 4;
               r_wd[m]   = $urandom;
            end
         end
         cpu_req = pend[0]; cpu_we = r_we[0]; cpu_be = r_be[0]; cpu_addr = r_addr[0]; cpu_wdata = r_wd[0];
         dma_req = pend[1]; dma_we = r_we[1]; dma_be = r_be[1]; dma_addr = r_addr[1]; dma_wdata = r_wd[1];
         prev_req[0] = pend[0];
         prev_req[1] = pend[1];
      end
      idle_inputs();
      cyc();
      for (int i = 16; i < 32; i++) begin
         n_total++; if (mem[i] !== exp_mem[i]) $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[i], exp_mem[i]); else n_pass++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_burst();
      test_reset_access();
      test_be_zero();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
